// File: rtl/alp.sv
// -----------------------------------------------------------------------------
// alp -- small 4-bit arithmetic/logic processor.
//
// Two operands (A, B) are written one at a time through data_in on load
// cycles, alternating A, B, A, B ...  A comp cycle applies op to the current
// operands and registers the result on out_1/out_0 with an error flag.
// Operands persist across comps, so several ops can reuse the same pair.
//
// Ports
//   clk      rising-edge clock
//   clr      synchronous active-high clear, highest priority
//   data_in  4-bit operand value, captured on a load cycle
//   op       3-bit operation select, sampled on a comp cycle
//   load     operand-write strobe
//   comp     compute strobe
//   out_0    registered result, low nibble / primary result
//   out_1    registered result, high nibble / secondary result
//   err      registered error flag for the most recent load/comp cycle
// -----------------------------------------------------------------------------
module alp (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] data_in,
  input  logic [2:0] op,
  input  logic       load,
  input  logic       comp,
  output logic [3:0] out_0,
  output logic [3:0] out_1,
  output logic       err
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  logic [3:0] a_q, b_q;
  logic       wp_q;    // 0: next load writes A, 1: next load writes B
  logic       bval_q;  // B written since last clr

  logic [3:0] res_0, res_1;
  logic       res_err;
  logic [4:0] sum;
  logic [7:0] prod;

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign prod = {4'd0, a_q} * {4'd0, b_q};

  // Combinational result of op on the current operands.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    res_0   = 4'd0;
    res_1   = 4'd0;
    res_err = 1'b0;
    unique case (op_e'(op))
      OP_ADD: begin
        res_0 = sum[3:0];
        res_1 = {3'b000, sum[4]};
      end
      OP_SUB: begin
        res_0   = a_q - b_q;
        res_err = (a_q < b_q);
      end
      OP_MUL: begin
        res_0 = prod[3:0];
        res_1 = prod[7:4];
      end
      OP_DIV: begin
        // Divide by zero reports an error and forces a zero result.
        if (b_q == 4'd0) begin
          res_err = 1'b1;
        end else begin
          res_0 = a_q / b_q;
          res_1 = a_q % b_q;
        end
      end
      OP_AND: res_0 = a_q & b_q;
      OP_OR:  res_0 = a_q | b_q;
      OP_XOR: res_0 = a_q ^ b_q;
      OP_CMP: res_0 = {1'b0, (a_q < b_q), (a_q > b_q), (a_q == b_q)};
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      wp_q   <= 1'b0;
      bval_q <= 1'b0;
      out_0  <= 4'd0;
      out_1  <= 4'd0;
      err    <= 1'b0;
    end else if (load && comp) begin
      // Conflicting strobes: flag it and touch nothing else.
      err <= 1'b1;
    end else if (load) begin
      if (!wp_q) begin
        a_q <= data_in;
      end else begin
        b_q    <= data_in;
        bval_q <= 1'b1;
      end
      wp_q <= ~wp_q;
      err  <= 1'b0;
    end else if (comp) begin
      if (bval_q) begin
        out_0 <= res_0;
        out_1 <= res_1;
        err   <= res_err;
      end else begin
        // No complete operand pair yet: outputs hold, only err reports it.
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alp.sv
// -----------------------------------------------------------------------------
// tb_alp -- directed self-checking bench for alp.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that should have updated them.
// -----------------------------------------------------------------------------
module tb_alp;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic [2:0] op = 3'd0;
  logic       load = 1'b0;
  logic       comp = 1'b0;
  logic [3:0] out_0, out_1;
  logic       err;

  int errors = 0;
  int checks = 0;

  alp dut (
    .clk     (clk),
    .clr     (clr),
    .data_in (data_in),
    .op      (op),
    .load    (load),
    .comp    (comp),
    .out_0   (out_0),
    .out_1   (out_1),
    .err     (err)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given strobes; returns after outputs settle.
  task automatic cyc(input logic c, input logic l, input logic m,
                     input logic [3:0] d, input logic [2:0] o);
    @(negedge clk);
    clr = c; load = l; comp = m; data_in = d; op = o;
    @(posedge clk);
    #1;
    clr = 1'b0; load = 1'b0; comp = 1'b0;
  endtask

  task automatic do_clr;                        cyc(1'b1, 1'b0, 1'b0, 4'd0, 3'd0); endtask
  task automatic do_load(input logic [3:0] d);  cyc(1'b0, 1'b1, 1'b0, d, 3'd0);    endtask
  task automatic do_comp(input logic [2:0] o);  cyc(1'b0, 1'b0, 1'b1, 4'd0, o);    endtask
  task automatic do_idle;                       cyc(1'b0, 1'b0, 1'b0, 4'd0, 3'd0); endtask

  task automatic test_reset;
    do_clr();
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got out_1=%0d out_0=%0d err=%b, want 0 0 0", out_1, out_0, err);
    end
    // clr wins over simultaneous load+comp.
    cyc(1'b1, 1'b1, 1'b1, 4'd9, 3'd0);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL clr_priority: got out_1=%0d out_0=%0d err=%b, want 0 0 0", out_1, out_0, err);
    end
  endtask

  task automatic test_arith;
    do_clr(); do_load(4'd9); do_load(4'd8);
    do_comp(3'b000);
    checks++;
    if ({out_1, out_0, err} !== {4'd1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL add_9_8: got %0d %0d %b, want 1 1 0", out_1, out_0, err);
    end
    do_comp(3'b010);
    checks++;
    if ({out_1, out_0, err} !== {4'd4, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL mul_9_8: got %0d %0d %b, want 4 8 0", out_1, out_0, err);
    end
    do_comp(3'b001);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL sub_9_8: got %0d %0d %b, want 0 1 0", out_1, out_0, err);
    end
    do_load(4'd3); do_load(4'd5);
    do_comp(3'b001);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd14, 1'b1}) begin
      errors++;
      $display("FAIL sub_3_5: got %0d %0d %b, want 0 14 1", out_1, out_0, err);
    end
    // Idle holds everything, including err.
    do_idle();
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd14, 1'b1}) begin
      errors++;
      $display("FAIL idle_hold: got %0d %0d %b, want 0 14 1", out_1, out_0, err);
    end
    // A load clears err but leaves the results alone.
    do_load(4'd15);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd14, 1'b0}) begin
      errors++;
      $display("FAIL load_hold: got %0d %0d %b, want 0 14 0", out_1, out_0, err);
    end
    do_load(4'd15);
    do_comp(3'b000);
    checks++;
    if ({out_1, out_0, err} !== {4'd1, 4'd14, 1'b0}) begin
      errors++;
      $display("FAIL add_15_15: got %0d %0d %b, want 1 14 0", out_1, out_0, err);
    end
    do_comp(3'b010);
    checks++;
    if ({out_1, out_0, err} !== {4'd14, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL mul_15_15: got %0d %0d %b, want 14 1 0", out_1, out_0, err);
    end
  endtask

  task automatic test_div;
    do_clr(); do_load(4'd13); do_load(4'd4);
    do_comp(3'b011);
    checks++;
    if ({out_1, out_0, err} !== {4'd1, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL div_13_4: got %0d %0d %b, want 1 3 0", out_1, out_0, err);
    end
    // Third load overwrites A only; B stays 4.
    do_load(4'd6);
    do_comp(3'b011);
    checks++;
    if ({out_1, out_0, err} !== {4'd2, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL div_wrap_6_4: got %0d %0d %b, want 2 1 0", out_1, out_0, err);
    end
    do_load(4'd0);
    do_comp(3'b011);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL div_by_zero: got %0d %0d %b, want 0 0 1", out_1, out_0, err);
    end
    do_comp(3'b001);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd6, 1'b0}) begin
      errors++;
      $display("FAIL sub_6_0: got %0d %0d %b, want 0 6 0", out_1, out_0, err);
    end
  endtask

  task automatic test_logic;
    logic [2:0] ops [4]  = '{3'b100, 3'b101, 3'b110, 3'b111};
    logic [3:0] want [4] = '{4'd8, 4'd14, 4'd6, 4'd2};
    do_clr(); do_load(4'd12); do_load(4'd10);
    for (int i = 0; i < 4; i++) begin
      do_comp(ops[i]);
      checks++;
      if ({out_1, out_0, err} !== {4'd0, want[i], 1'b0}) begin
        errors++;
        $display("FAIL logic_op%0d: got %0d %0d %b, want 0 %0d 0", ops[i], out_1, out_0, err, want[i]);
      end
    end
    do_load(4'd7); do_load(4'd7);
    do_comp(3'b111);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL cmp_equal: got %0d %0d %b, want 0 1 0", out_1, out_0, err);
    end
    do_load(4'd2); do_load(4'd9);
    do_comp(3'b111);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL cmp_less: got %0d %0d %b, want 0 4 0", out_1, out_0, err);
    end
  endtask

  task automatic test_errors;
    do_clr(); do_load(4'd5);
    do_comp(3'b000);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL comp_no_b: got %0d %0d %b, want 0 0 1", out_1, out_0, err);
    end
    cyc(1'b0, 1'b1, 1'b1, 4'd9, 3'd0);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL load_and_comp: got %0d %0d %b, want 0 0 1", out_1, out_0, err);
    end
    // A must still be 5 and the next load must go to B.
    do_load(4'd8);
    do_comp(3'b000);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd13, 1'b0}) begin
      errors++;
      $display("FAIL after_conflict_add: got %0d %0d %b, want 0 13 0", out_1, out_0, err);
    end
  endtask

  task automatic test_clr_mid;
    do_clr(); do_load(4'd4);
    do_clr(); do_load(4'd7); do_load(4'd2);
    do_comp(3'b000);
    checks++;
    if ({out_1, out_0, err} !== {4'd0, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL clr_mid_add: got %0d %0d %b, want 0 9 0", out_1, out_0, err);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div();
    test_logic();
    test_errors();
    test_clr_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alp.md
ALP -- requirements
Module: alp

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 clr  input  1  synchronous, active-high reset; highest priority.
REQ-004 data_in  input  4  operand value captured on a load cycle.
REQ-005 op  input  3  operation select, sampled on a comp cycle.
REQ-006 load  input  1  operand-write strobe, level-sampled each rising edge.
REQ-007 comp  input  1  compute strobe, level-sampled each rising edge.
REQ-008 out_0  output  4  registered result, low nibble / primary result.
REQ-009 out_1  output  4  registered result, high nibble / secondary result.
REQ-010 err  output  1  registered error flag for the most recent load/comp cycle.

Function
REQ-011 Internal state: operand registers A[3:0] and B[3:0], a write pointer wp (0=A, 1=B), and a flag bval set when B has been written since the last clr.
REQ-012 Load cycle (load=1, comp=0): data_in is written to A if wp=0, else to B; wp toggles; writing B sets bval; out_0/out_1 hold; err <= 0.
REQ-013 Load sequence wraps: loads 1,2,3,4 write A,B,A,B; a third load overwrites A and keeps the old B.
REQ-014 Comp cycle (load=0, comp=1, bval=1): out_0/out_1/err update at that rising edge, one cycle latency; the result is visible until the next comp or clr.
REQ-015 op=000 ADD: {out_1,out_0} = A+B (5-bit sum; out_1 = {3'b000,carry}); err=0.
REQ-016 op=001 SUB: out_0 = (A-B) mod 16; out_1=0; err=1 if A<B, else 0.
REQ-017 op=010 MUL: {out_1,out_0} = A*B, full 8-bit unsigned product; err=0.
REQ-018 op=011 DIV: out_0 = A/B, out_1 = A%B, unsigned; if B=0 then out_0=0, out_1=0, err=1.
REQ-019 op=100 AND, 101 OR, 110 XOR: out_0 = bitwise A op B; out_1=0; err=0.
REQ-020 op=111 CMP: out_0 = {1'b0, A<B, A>B, A==B}; out_1=0; err=0.
REQ-021 All arithmetic is unsigned.
REQ-022 Comp with bval=0 (B not yet loaded since clr): err <= 1; out_0/out_1 hold; no other state change.
REQ-023 load=1 and comp=1 in the same cycle: err <= 1; A, B, wp, bval, out_0 and out_1 are all unchanged.
REQ-024 Idle cycle (load=0, comp=0): all state and outputs hold, including err.
REQ-025 Operands are not consumed by comp; repeated comps with different op reuse the same A and B.

Reset
REQ-026 clr=1 at a rising edge sets A=0, B=0, wp=0, bval=0, out_0=0, out_1=0, err=0.
REQ-027 clr overrides load and comp in the same cycle.
REQ-028 clr mid-sequence (for example, after only A was loaded) discards the partial load; the next load writes A.
REQ-029 No asynchronous reset path; before the first clr, state is undefined.

Verification
REQ-030 clr; load 9; load 8; comp op=000 -> out_1=1, out_0=1, err=0.
REQ-031 Same A=9, B=8: comp op=010 -> out_1=4, out_0=8 (product 72); then op=001 -> out_0=1, err=0; swap to A=3, B=5, op=001 -> out_0=14, err=1.
REQ-032 A=13, B=4, op=011 -> out_0=3, out_1=1; with B=0, op=011 -> out_0=0, out_1=0, err=1.
REQ-033 A=12, B=10: op=100/101/110 -> out_0=8/14/6; op=111 -> out_0=2.
REQ-034 clr; load 5; comp -> err=1, out_0=out_1=0; load+comp asserted together -> err=1, A/B unchanged.
REQ-035 Load A, then assert clr, then load 7 and 2, comp op=000 -> out_0=9, out_1=0.
